dsp_mem_bank_trig: RTL

Parametrised, trigger-based successor to the fixed-size memory bank, capturing a DSP sample stream into a circular buffer of `BankDepth` × `MemWidth` registers in the write-clock domain. Capture is pre/post-trigger: the buffer fills continuously once armed, and on trigger it records a programmable number of further samples. The captured window is then drained oldest-first through a valid/ready stream port with optional snake bit-order flipping. The block sits between the DSP datapath tap and the scan/debug readout logic.

---
 rtl/dsp_mem_bank_trig.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dsp_mem_bank_trig.sv
// Trigger-based capture bank: circular pre/post-trigger sample buffer in the
// write-clock domain, drained oldest-first through a registered valid/ready port.
module dsp_mem_bank_trig #(
    parameter int MemWidth  = 16,
    parameter int BankDepth = 8,
    parameter int SnakeFlip = 0,
    parameter int CntWidth  = $clog2(BankDepth + 1)
) (
    input  logic                i_wclk,
    input  logic                rst_sync_write,
    input  logic                i_cfg_arm,
    input  logic                i_cfg_abort,
    input  logic [CntWidth-1:0] i_cfg_post_cnt,
    input  logic                i_trig,
    input  logic                i_dat_valid,
    input  logic [MemWidth-1:0] i_dat,
    input  logic                i_rd_start,
    output logic                o_rd_valid,
    output logic [MemWidth-1:0] o_rd_dat,
    output logic                o_rd_last,
    input  logic                i_rd_ready,
    output logic [2:0]          o_state,
    output logic [CntWidth-1:0] o_fill,
    output logic                o_done
);

    localparam int PtrWidth = (BankDepth > 2) ? $clog2(BankDepth) : 1;
    localparam int AccWidth = CntWidth + 1;
    localparam logic [PtrWidth-1:0] PtrMax   = PtrWidth'(BankDepth - 1);
    localparam logic [PtrWidth-1:0] PtrOne   = PtrWidth'(1);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(BankDepth);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_TRIG  = 3'd2,
        ST_FULL  = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [MemWidth-1:0]   mem_q [BankDepth];
    logic [PtrWidth-1:0]   wptr_q, wptr_d;
    logic [PtrWidth-1:0]   rptr_q, rptr_d;
    logic [CntWidth-1:0]   fill_q, fill_d;
    logic [CntWidth-1:0]   rem_q, rem_d;
    logic [CntWidth-1:0]   k_q, k_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [MemWidth-1:0]   rd_dat_q, rd_dat_d;
    logic                  rd_last_q, rd_last_d;
    logic                  done_q;

    logic                  wr_en;
    logic [CntWidth-1:0]   rem_v;
    logic [CntWidth-1:0]   post_clamp;
    logic [AccWidth-1:0]   wptr_ext, fill_ext, start_ext;
    logic [PtrWidth-1:0]   rptr_start, rptr_inc;

    function automatic logic [MemWidth-1:0] bit_rev(input logic [MemWidth-1:0] x);
        logic [MemWidth-1:0] r;
        for (int i = 0; i < MemWidth; i++) begin
            r[i] = x[MemWidth-1-i];
        end
        return r;
    endfunction

    // Oldest-entry pointer and post-count clamp, used when readout/trigger fire.
    always_comb begin
        wptr_ext   = AccWidth'(wptr_q);
        fill_ext   = AccWidth'(fill_q);
        start_ext  = (wptr_ext >= fill_ext) ? (wptr_ext - fill_ext)
                                            : (wptr_ext + AccWidth'(BankDepth) - fill_ext);
        rptr_start = PtrWidth'(start_ext);
        rptr_inc   = (rptr_q == PtrMax) ? '0 : (rptr_q + PtrOne);
        post_clamp = (i_cfg_post_cnt > DepthCnt) ? DepthCnt : i_cfg_post_cnt;
    end

    // Next-state and datapath control; abort overrides everything.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fill_d     = fill_q;
        rem_d      = rem_q;
        k_d        = k_q;
        rd_valid_d = rd_valid_q;
        rd_dat_d   = rd_dat_q;
        rd_last_d  = rd_last_q;
        wr_en      = 1'b0;
        rem_v      = rem_q;

        if (i_cfg_abort) begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_cfg_arm) begin
                        wptr_d  = '0;
                        fill_d  = '0;
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (i_trig) begin
                        rem_v = post_clamp;
                        // The trigger-cycle sample is only kept if it is a post sample.
                        if (i_dat_valid && (rem_v != '0)) begin
                            wr_en = 1'b1;
                            rem_v = rem_v - CntOne;
                        end
                        rem_d   = rem_v;
                        state_d = (rem_v == '0) ? ST_FULL : ST_TRIG;
                    end else if (i_dat_valid) begin
                        wr_en = 1'b1;
                    end
                end
                ST_TRIG: begin
                    if (i_dat_valid) begin
                        wr_en = 1'b1;
                        rem_d = rem_q - CntOne;
                        if (rem_q == CntOne) begin
                            state_d = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (i_rd_start) begin
                        if (fill_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            rptr_d     = rptr_start;
                            k_d        = '0;
                            rd_valid_d = 1'b1;
                            rd_dat_d   = mem_q[rptr_start];
                            rd_last_d  = (fill_q == CntOne);
                            state_d    = ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_valid_q && i_rd_ready) begin
                        if (k_q == fill_q - CntOne) begin
                            rd_valid_d = 1'b0;
                            rd_last_d  = 1'b0;
                            state_d    = ST_IDLE;
                        end else begin
                            rptr_d     = rptr_inc;
                            k_d        = k_q + CntOne;
                            rd_dat_d   = ((SnakeFlip != 0) && k_d[0]) ? bit_rev(mem_q[rptr_inc])
                                                                      : mem_q[rptr_inc];
                            rd_last_d  = (k_d == fill_q - CntOne);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (wr_en) begin
            wptr_d = (wptr_q == PtrMax) ? '0 : (wptr_q + PtrOne);
            fill_d = (fill_q == DepthCnt) ? fill_q : (fill_q + CntOne);
        end
    end

    // State, pointers, counters and registered outputs.
    always_ff @(posedge i_wclk or posedge rst_sync_write) begin
        if (rst_sync_write) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fill_q     <= '0;
            rem_q      <= '0;
            k_q        <= '0;
            rd_valid_q <= 1'b0;
            rd_dat_q   <= '0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fill_q     <= fill_d;
            rem_q      <= rem_d;
            k_q        <= k_d;
            rd_valid_q <= rd_valid_d;
            rd_dat_q   <= rd_dat_d;
            rd_last_q  <= rd_last_d;
            done_q     <= (state_d == ST_FULL);
        end
    end

    // Sample storage; written only while capturing.
    always_ff @(posedge i_wclk or posedge rst_sync_write) begin
        if (rst_sync_write) begin
            for (int i = 0; i < BankDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wptr_q] <= i_dat;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_dat   = rd_dat_q;
    assign o_rd_last  = rd_last_q;
    assign o_state    = state_q;
    assign o_fill     = fill_q;
    assign o_done     = done_q;

endmodule
